fifo_rd_checker: RTL and testbench

FIFO_RD_CHECKER -- requirements
Module: fifo_rd_checker

---
 rtl/fifo_chk_pkg.sv | 6 +
 rtl/fifo_chk_pattern.sv | 18 +
 rtl/fifo_rd_checker.sv | 86 ++++++++
 tb/tb_fifo_rd_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_chk_pkg.sv
// fifo_chk_pkg: types and defaults shared by the FIFO read checker and the write-side tester
package fifo_chk_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_CNT_W = 32;
endpackage

// File: rtl/fifo_chk_pattern.sv
// fifo_chk_pattern: expected-word generator, loads SEED and counts up modulo 2^DATA_W
module fifo_chk_pattern
    import fifo_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SEED = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    output logic [DATA_W-1:0] value
);
    always_ff @(posedge clk) begin
        if (rst || load) value <= SEED;
        else if (adv) value <= value + DATA_W'(1);
    end
endmodule

// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: drains NUM_WORDS words from a FIFO and compares them against an incrementing pattern
module fifo_rd_checker
    import fifo_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_WORDS = 4096,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ERR_W = 16,
    parameter logic [DATA_W-1:0] SEED = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              empty,
    input  logic [DATA_W-1:0] rdata,
    output logic              ren,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS);
    state_t state, state_nxt;
    logic [CNT_W-1:0] issued;
    logic [DATA_W-1:0] expected;
    logic rd_vld, start_ok, last_issue, mism;
    assign start_ok = start && (state == IDLE || state == DONE);
    assign mism = rd_vld && (rdata != expected);
    // leave RUN on the edge that issues the last read so DRAIN holds the final compare
    assign last_issue = ren && (issued + CNT_W'(1) == LAST);
    fifo_chk_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_pattern (
        .clk(clk),
        .rst(rst),
        .load(start_ok),
        .adv(rd_vld),
        .value(expected)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: state_nxt = start ? RUN : state;
            RUN:        state_nxt = (last_issue || issued == LAST) ? DRAIN : RUN;
            DRAIN:      state_nxt = DONE;
        endcase
    end
    always_comb begin
        ren = (state == RUN) && !empty && (issued != LAST);
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
        pass = done && (err_cnt == '0) && (word_cnt == LAST);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            issued <= '0;
            rd_vld <= 1'b0;
            word_cnt <= '0;
            err_cnt <= '0;
            first_err_idx <= '0;
            first_err_data <= '0;
        end else begin
            rd_vld <= ren;
            if (start_ok) begin
                issued <= '0;
                word_cnt <= '0;
                err_cnt <= '0;
                first_err_idx <= '0;
                first_err_data <= '0;
            end else begin
                if (ren) issued <= issued + CNT_W'(1);
                if (rd_vld) word_cnt <= word_cnt + CNT_W'(1);
                if (mism && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                if (mism && err_cnt == '0) begin
                    first_err_idx <= word_cnt;
                    first_err_data <= rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_checker.sv
// tb_fifo_rd_checker: table-driven runs through a FIFO model with a result scoreboard
module tb_fifo_rd_checker;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic start_a = 0, empty_a, ren_a, busy_a, done_a, pass_a;
    logic [63:0] rdata_a = '0, fdata_a;
    logic [31:0] wc_a, fidx_a;
    logic [3:0] err_a;
    logic start_b = 0, empty_b, ren_b, busy_b, done_b, pass_b;
    logic [63:0] rdata_b = '0, fdata_b;
    logic [31:0] wc_b, fidx_b;
    logic [15:0] err_b;

    fifo_rd_checker #(.NUM_WORDS(16), .ERR_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .empty(empty_a), .rdata(rdata_a),
        .ren(ren_a), .busy(busy_a), .done(done_a), .pass(pass_a), .word_cnt(wc_a),
        .err_cnt(err_a), .first_err_idx(fidx_a), .first_err_data(fdata_a)
    );
    fifo_rd_checker #(.NUM_WORDS(4), .SEED(64'hFFFF_FFFF_FFFF_FFFE)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .empty(empty_b), .rdata(rdata_b),
        .ren(ren_b), .busy(busy_b), .done(done_b), .pass(pass_b), .word_cnt(wc_b),
        .err_cnt(err_b), .first_err_idx(fidx_b), .first_err_data(fdata_b)
    );

    typedef struct {
        logic [15:0] corrupt;
        logic [63:0] bad;
        bit gap;
        bit poke;
        bit pass;
        int wc;
        int err;
        int idx;
        logic [63:0] data;
    } vec_t;
    typedef struct {
        bit pass;
        int wc;
        int err;
        int idx;
        logic [63:0] data;
    } res_t;
    vec_t vecs[5];
    res_t sb[$];
    int checks = 0, errors = 0;

    // FIFO model for dut_a: registered read data, optional empty gaps of 3 cycles
    logic [63:0] mem_a[16];
    int rptr_a = 0, gcnt = 0, cyc = 0;
    bit gap_en = 0;
    assign empty_a = (rptr_a >= 16) || (gap_en && (gcnt % 6 < 3));
    always @(posedge clk) begin
        gcnt <= gcnt + 1;
        cyc <= cyc + 1;
        if (start_a) rptr_a <= 0;
        else if (ren_a) begin
            rdata_a <= mem_a[rptr_a];
            rptr_a <= rptr_a + 1;
        end
    end

    logic [63:0] mem_b[4];
    int rptr_b = 0;
    assign empty_b = rptr_b >= 4;
    always @(posedge clk) begin
        if (start_b) rptr_b <= 0;
        else if (ren_b) begin
            rdata_b <= mem_b[rptr_b];
            rptr_b <= rptr_b + 1;
        end
    end

    int viol = 0, ren_cnt = 0, last_ren = 0, done_cyc = 0;
    bit done_q = 0;
    always @(negedge clk) begin
        if (ren_a && empty_a) viol++;
        if (ren_a) begin
            ren_cnt++;
            last_ren = cyc;
        end
        if (done_a && !done_q) done_cyc = cyc;
        done_q = done_a;
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        res_t r;
        for (int i = 0; i < 16; i++) mem_a[i] = v.corrupt[i] ? v.bad : 64'(i);
        gap_en = v.gap;
        sb.push_back('{v.pass, v.wc, v.err, v.idx, v.data});
        ren_cnt = 0;
        viol = 0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        chk("busy_run", 64'(busy_a), 64'(1));
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_a) break;
            start_a = v.poke && (i % 4 == 1);
        end
        start_a = 0;
        chk("done_timeout", 64'(done_a), 64'(1));
        @(negedge clk);
        r = sb.pop_front();
        chk("pass", 64'(pass_a), 64'(r.pass));
        chk("word_cnt", 64'(wc_a), 64'(r.wc));
        chk("err_cnt", 64'(err_a), 64'(r.err));
        chk("first_err_idx", 64'(fidx_a), 64'(r.idx));
        chk("first_err_data", fdata_a, r.data);
        chk("ren_count", 64'(ren_cnt), 64'(16));
        chk("ren_while_empty", 64'(viol), 64'(0));
        if (!v.gap) chk("done_latency", 64'(done_cyc - last_ren), 64'(2));
        repeat (3) @(negedge clk);
        chk("hold_done", 64'(done_a), 64'(1));
        chk("hold_word_cnt", 64'(wc_a), 64'(r.wc));
        chk("hold_err_cnt", 64'(err_a), 64'(r.err));
    endtask

    initial begin
        vecs[0] = '{16'h0000, 64'h0, 0, 0, 1, 16, 0, 0, 64'h0};
        vecs[1] = '{16'h0020, 64'hDEAD, 0, 0, 0, 16, 1, 5, 64'hDEAD};
        vecs[2] = '{16'h0000, 64'h0, 1, 0, 1, 16, 0, 0, 64'h0};
        vecs[3] = '{16'h0208, 64'hBEEF, 1, 0, 0, 16, 2, 3, 64'hBEEF};
        vecs[4] = '{16'hFFFF, 64'hDEAD, 0, 1, 0, 16, 15, 0, 64'hDEAD};
        mem_b[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        mem_b[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        mem_b[2] = 64'h0;
        mem_b[3] = 64'h1;
        repeat (2) @(negedge clk);
        chk("rst_ren", 64'(ren_a), 64'(0));
        chk("rst_busy", 64'(busy_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        chk("rst_pass", 64'(pass_a), 64'(0));
        chk("rst_word_cnt", 64'(wc_a), 64'(0));
        chk("rst_err_cnt", 64'(err_a), 64'(0));
        rst = 0;
        @(negedge clk);
        foreach (vecs[k]) run_vec(vecs[k]);
        // reset wins over a simultaneous start
        rst = 1;
        start_a = 1;
        @(negedge clk);
        rst = 0;
        start_a = 0;
        chk("rst_start_busy", 64'(busy_a), 64'(0));
        chk("rst_start_done", 64'(done_a), 64'(0));
        chk("rst_start_word_cnt", 64'(wc_a), 64'(0));
        @(negedge clk);
        chk("rst_start_idle", 64'(busy_a), 64'(0));
        // reset in the middle of a run
        for (int i = 0; i < 16; i++) mem_a[i] = 64'(i);
        gap_en = 0;
        ren_cnt = 0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        for (int i = 0; i < 50 && ren_cnt < 7; i++) @(negedge clk);
        chk("midrun_reads", 64'(ren_cnt >= 7), 64'(1));
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrun_ren", 64'(ren_a), 64'(0));
        chk("midrun_busy", 64'(busy_a), 64'(0));
        chk("midrun_word_cnt", 64'(wc_a), 64'(0));
        run_vec(vecs[0]);
        // wrap-around from all-ones to zero
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            if (pass_i == 1) mem_b[2] = 64'h1;
            start_b = 1;
            @(negedge clk);
            start_b = 0;
            for (int i = 0; i < 50 && !done_b; i++) @(negedge clk);
            chk("wrap_done", 64'(done_b), 64'(1));
            chk("wrap_pass", 64'(pass_b), 64'(pass_i == 0));
            chk("wrap_word_cnt", 64'(wc_b), 64'(4));
            chk("wrap_err_cnt", 64'(err_b), 64'(pass_i));
            chk("wrap_first_idx", 64'(fidx_b), 64'(pass_i == 1 ? 2 : 0));
            chk("wrap_first_data", fdata_b, 64'(pass_i));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
